// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state encodings, drive levels and sizing helper for the SR latch driver
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // The downstream NAND latch is driven active-low.
    localparam logic DRIVE_OFF = 1'b1;
    localparam logic DRIVE_ON  = 1'b0;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - two-flop synchronizer, stability counter and rising-edge event for one button
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized value disagrees with the
    // held level; a single agreeing sample restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - debounced buttons to non-overlapping active-low set/reset pulses
module sr_drive_ctrl
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic busy
);

    localparam int PW = cnt_width(PULSE_CYCLES);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    logic          rise_s;
    logic          rise_r;
    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pulse_cnt;
    logic [GW-1:0] gap_cnt;
    logic          s_n;
    logic          r_n;
    logic          busy_n;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_set),
        .rise (rise_s)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_rst),
        .rise (rise_r)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (rise_s && !rise_r) begin
                    state_n = ST_PULSE_S;
                end else if (rise_r && !rise_s) begin
                    state_n = ST_PULSE_R;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered drives line up
    // with the registered state; only one of S/R can ever be selected.
    always_comb begin
        s_n    = (state_n == ST_PULSE_S) ? DRIVE_ON : DRIVE_OFF;
        r_n    = (state_n == ST_PULSE_R) ? DRIVE_ON : DRIVE_OFF;
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            S         <= DRIVE_OFF;
            R         <= DRIVE_OFF;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            S     <= s_n;
            R     <= r_n;
            busy  <= busy_n;
            if ((state == ST_PULSE_S || state == ST_PULSE_R) && state_n == state) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end else begin
                pulse_cnt <= '0;
            end
            if (state == ST_GAP && state_n == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb/tb_sr_drive_ctrl.sv - directed and randomized checks of sr_drive_ctrl against a timeline model
module tb_sr_drive_ctrl;

    localparam int DEB   = 4;
    localparam int PULSE = 3;
    localparam int GAP   = 2;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic S;
    logic R;
    logic busy;

    sr_drive_ctrl #(
        .DEB_CYCLES  (DEB),
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_set(btn_set),
        .btn_rst(btn_rst),
        .S      (S),
        .R      (R),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: raw sample history per button, debounced levels, and a burst timeline.
    bit raw_s_q[$];
    bit raw_r_q[$];
    bit lvl_s, lvl_r, pend_s, pend_r;
    bit m_active, m_kind_s, m_q;
    int m_pos;

    function automatic bit deb_level(input bit hist[$], input bit lvl);
        int last;
        last = hist.size() - 3;
        if (last - DEB < 0) return lvl;
        for (int i = last - DEB; i <= last; i++) begin
            if (hist[i] == lvl) return lvl;
        end
        return !lvl;
    endfunction

    task automatic model_reset();
        raw_s_q.delete();
        raw_r_q.delete();
        lvl_s = 0; lvl_r = 0; pend_s = 0; pend_r = 0;
        m_active = 0; m_kind_s = 0; m_pos = 0;
    endtask

    task automatic model_step();
        bit ns, nr;
        if (m_active) begin
            m_pos++;
            if (m_pos == PULSE + GAP) m_active = 0;
        end else if (pend_s != pend_r) begin
            m_active = 1;
            m_kind_s = pend_s;
            m_pos    = 0;
            m_q      = pend_s;
        end
        raw_s_q.push_back(btn_set);
        raw_r_q.push_back(btn_rst);
        if (raw_s_q.size() > 32) begin
            void'(raw_s_q.pop_front());
            void'(raw_r_q.pop_front());
        end
        ns = deb_level(raw_s_q, lvl_s);
        nr = deb_level(raw_r_q, lvl_r);
        pend_s = ns && !lvl_s;
        pend_r = nr && !lvl_r;
        lvl_s = ns;
        lvl_r = nr;
    endtask

    initial begin
        m_q = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                edge_n++;
                model_step();
            end
        end
    end

    // Per-cycle compare plus pulse statistics for the directed scenarios.
    bit q = 0;
    bit prev_s = 1, prev_r = 1;
    int s_pulses, r_pulses, s_low, r_low, busy_cnt, s_fall, r_fall;

    task automatic clear_stats();
        s_pulses = 0; r_pulses = 0; s_low = 0; r_low = 0;
        busy_cnt = 0; s_fall = -1; r_fall = -1;
    endtask

    initial begin
        bit es, er, eb;
        clear_stats();
        forever begin
            @(negedge clk);
            es = !(m_active && m_kind_s && m_pos < PULSE);
            er = !(m_active && !m_kind_s && m_pos < PULSE);
            eb = m_active;
            checks++;
            if ({S, R, busy} !== {es, er, eb}) begin
                errors++;
                $display("FAIL outputs edge %0d: S R busy got %b %b %b want %b %b %b",
                         edge_n, S, R, busy, es, er, eb);
            end
            checks++;
            if (S === 1'b0 && R === 1'b0) begin
                errors++;
                $display("FAIL overlap edge %0d: S=%b R=%b both driven, want never", edge_n, S, R);
            end
            if (S === 1'b0) q = 1'b1;
            else if (R === 1'b0) q = 1'b0;
            checks++;
            if (q !== m_q) begin
                errors++;
                $display("FAIL latch_q edge %0d: got %b want %b", edge_n, q, m_q);
            end
            if (S === 1'b0 && prev_s) begin s_pulses++; s_fall = edge_n; end
            if (R === 1'b0 && prev_r) begin r_pulses++; r_fall = edge_n; end
            if (S === 1'b0) s_low++;
            if (R === 1'b0) r_low++;
            if (busy === 1'b1) busy_cnt++;
            prev_s = (S !== 1'b0);
            prev_r = (R !== 1'b0);
        end
    end

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int guard;

    initial begin
        // Reset state
        wait_cycles(3);
        expect_int("reset_S", int'(S), 1);
        expect_int("reset_R", int'(R), 1);
        expect_int("reset_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        wait_cycles(3);

        // Clean set press
        clear_stats();
        base = edge_n;
        btn_set = 1'b1;
        wait_cycles(20);
        btn_set = 1'b0;
        wait_cycles(15);
        expect_int("s1_pulses", s_pulses, 1);
        expect_int("s1_latency", s_fall - (base + 1), 7);
        expect_int("s1_width", s_low, 3);
        expect_int("s1_r_low", r_low, 0);
        expect_int("s1_busy", busy_cnt, 5);

        // Bouncing reset button, then stable
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            btn_rst = 1'b1;
            wait_cycles(2);
            btn_rst = 1'b0;
            wait_cycles(2);
        end
        base = edge_n;
        btn_rst = 1'b1;
        wait_cycles(20);
        btn_rst = 1'b0;
        wait_cycles(15);
        expect_int("s2_pulses", r_pulses, 1);
        expect_int("s2_latency", r_fall - (base + 1), 7);
        expect_int("s2_width", r_low, 3);
        expect_int("s2_s_pulses", s_pulses, 0);

        // Simultaneous press
        clear_stats();
        btn_set = 1'b1;
        btn_rst = 1'b1;
        wait_cycles(20);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        wait_cycles(15);
        expect_int("s3_s_pulses", s_pulses, 0);
        expect_int("s3_r_pulses", r_pulses, 0);
        expect_int("s3_busy", busy_cnt, 0);

        // Reset event arriving during a set pulse
        clear_stats();
        btn_set = 1'b1;
        wait_cycles(3);
        btn_rst = 1'b1;
        wait_cycles(20);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        wait_cycles(15);
        expect_int("s4_s_pulses", s_pulses, 1);
        expect_int("s4_r_pulses", r_pulses, 0);
        expect_int("s4_busy", busy_cnt, 5);
        expect_int("s4_idle", int'(busy), 0);

        // Reset dropped in the second cycle of a set pulse
        clear_stats();
        btn_set = 1'b1;
        guard = 0;
        while (S !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        expect_int("s5_pulse_seen", int'(S), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_int("s5_async_S", int'(S), 1);
        expect_int("s5_async_R", int'(R), 1);
        expect_int("s5_async_busy", int'(busy), 0);
        @(negedge clk);
        btn_set = 1'b0;
        wait_cycles(3);
        #2 rst_n = 1'b1;
        clear_stats();
        wait_cycles(30);
        expect_int("s5_no_resume", s_pulses, 0);
        expect_int("s5_no_busy", busy_cnt, 0);

        // Button already held at reset release
        @(negedge clk);
        #2 rst_n = 1'b0;
        btn_set = 1'b1;
        wait_cycles(3);
        #2 rst_n = 1'b1;
        clear_stats();
        base = edge_n;
        wait_cycles(20);
        expect_int("s6_pulses", s_pulses, 1);
        expect_int("s6_latency", s_fall - (base + 1), 7);
        btn_set = 1'b0;
        wait_cycles(15);

        // Randomized buttons with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            @(negedge clk);
            btn_set = ($urandom_range(0, 2) == 0);
            btn_rst = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 30) == 0) begin
                #2 rst_n = 1'b0;
                wait_cycles($urandom_range(1, 3));
                #2 rst_n = 1'b1;
            end
            wait_cycles($urandom_range(1, 12));
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        wait_cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
